// File: rtl/mips32_pkg.sv
// Shared definitions for the pipe_mips32 core.
// Purpose: opcode constants, the instruction-class enum, a class decoder and
//          the four pipeline-register structs (each carries a valid bit;
//          valid=0 marks a bubble).
// Ports:   none (package).
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0A;
  localparam logic [5:0] OP_SUBI  = 6'h0B;
  localparam logic [5:0] OP_SLTI  = 6'h0C;
  localparam logic [5:0] OP_BNEQZ = 6'h0D;
  localparam logic [5:0] OP_BEQZ  = 6'h0E;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  typedef enum logic [2:0] {
    RR_ALU,
    RM_ALU,
    LOAD,
    STORE,
    BRANCH,
    HALT,
    NOP
  } instr_class_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
  } if_id_t;

  typedef struct packed {
    logic         valid;
    instr_class_e cls;
    logic [5:0]   op;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   dest;
    logic         we;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  imm;
    logic [31:0]  pc;
  } id_ex_t;

  typedef struct packed {
    logic         valid;
    instr_class_e cls;
    logic [4:0]   dest;
    logic         we;
    logic [31:0]  alu;
    logic [31:0]  b;
  } ex_mem_t;

  typedef struct packed {
    logic         valid;
    instr_class_e cls;
    logic [4:0]   dest;
    logic         we;
    logic [31:0]  result;
  } mem_wb_t;

  function automatic instr_class_e decode_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      default:                                       return NOP;
    endcase
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU for pipe_mips32.
// Purpose: computes the EX-stage result from the opcode. Loads, stores and
//          any unlisted opcode fall through to addition (address generation).
// Ports:   op_i     opcode [5:0]
//          a_i      first operand [31:0]
//          b_i      second operand (register or sign-extended immediate) [31:0]
//          result_o 32-bit result, wrap-around arithmetic
module mips32_alu
  import mips32_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = a_i + b_i;
    case (op_i)
      OP_SUB, OP_SUBI: result_o = a_i - b_i;
      OP_AND:          result_o = a_i & b_i;
      OP_OR:           result_o = a_i | b_i;
      OP_SLT, OP_SLTI: result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
      OP_MUL:          result_o = a_i * b_i;
      default:         ;
    endcase
  end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage in-order MIPS32-subset core (IF, ID, EX, MEM, WB).
// Purpose: unified word-addressed Mem[], 32-entry Reg[], forwarding into EX,
//          branches resolved in EX with a two-slot flush, no load-use
//          interlock. Reg, Mem, PC, HALTED and TAKEN_BRANCH keep these names
//          so they can be preloaded and inspected hierarchically.
// Ports:   clk    rising-edge clock
//          rst_n  synchronous active-low reset
//          halted mirrors HALTED
module pipe_mips32
  import mips32_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int XLEN      = 32
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [XLEN-1:0] Reg [32];
  logic [XLEN-1:0] Mem [MEM_DEPTH];
  logic [31:0]     PC;
  logic            HALTED;
  logic            TAKEN_BRANCH;

  logic [31:0] pc_d;
  logic        stop_fetch_q, stop_fetch_d;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;

  // ---------------- ID ----------------
  logic [5:0]   id_op;
  logic [4:0]   id_rs, id_rt, id_rd;
  logic [31:0]  id_imm, id_a, id_b;
  instr_class_e id_cls;
  logic         id_is_hlt;
  logic         wb_write;

  assign id_op  = if_id_q.ir[31:26];
  assign id_rs  = if_id_q.ir[25:21];
  assign id_rt  = if_id_q.ir[20:16];
  assign id_rd  = if_id_q.ir[15:11];
  assign id_imm = {{16{if_id_q.ir[15]}}, if_id_q.ir[15:0]};
  assign id_cls = decode_class(id_op);
  assign id_is_hlt = if_id_q.valid && (id_cls == HALT);

  assign wb_write = mem_wb_q.valid && mem_wb_q.we && (mem_wb_q.dest != 5'd0);

  // Write-first register file: the value being written back this cycle is
  // visible to the ID read.
  always_comb begin
    id_a = '0;
    id_b = '0;
    if (id_rs != 5'd0)
      id_a = (wb_write && mem_wb_q.dest == id_rs) ? mem_wb_q.result : Reg[id_rs];
    if (id_rt != 5'd0)
      id_b = (wb_write && mem_wb_q.dest == id_rt) ? mem_wb_q.result : Reg[id_rt];
  end

  // ---------------- EX ----------------
  logic        exm_fwd;
  logic [31:0] ex_a, ex_b, alu_b, alu_y, branch_target;
  logic        branch_taken;

  // A load in EX/MEM has no data yet, so it is never a forwarding source;
  // the consumer right behind it sees the stale register value.
  assign exm_fwd = ex_mem_q.valid && ex_mem_q.we && (ex_mem_q.cls != LOAD) &&
                   (ex_mem_q.dest != 5'd0);

  always_comb begin
    ex_a = id_ex_q.a;
    ex_b = id_ex_q.b;
    if (exm_fwd && ex_mem_q.dest == id_ex_q.rs)       ex_a = ex_mem_q.alu;
    else if (wb_write && mem_wb_q.dest == id_ex_q.rs) ex_a = mem_wb_q.result;
    if (exm_fwd && ex_mem_q.dest == id_ex_q.rt)       ex_b = ex_mem_q.alu;
    else if (wb_write && mem_wb_q.dest == id_ex_q.rt) ex_b = mem_wb_q.result;
  end

  assign alu_b = (id_ex_q.cls == RR_ALU) ? ex_b : id_ex_q.imm;

  mips32_alu u_alu (
    .op_i     (id_ex_q.op),
    .a_i      (ex_a),
    .b_i      (alu_b),
    .result_o (alu_y)
  );

  assign branch_taken  = id_ex_q.valid && (id_ex_q.cls == BRANCH) &&
                         ((id_ex_q.op == OP_BEQZ) ? (ex_a == 32'd0) : (ex_a != 32'd0));
  assign branch_target = id_ex_q.pc + 32'd1 + id_ex_q.imm;

  // ---------------- next state ----------------
  logic fetch_en;
  assign fetch_en = !stop_fetch_q && !id_is_hlt;

  always_comb begin
    if_id_d  = '0;
    id_ex_d  = '0;
    ex_mem_d = '0;
    mem_wb_d = '0;
    pc_d     = PC;

    // A taken branch kills the instructions in IF and ID, including a HLT.
    stop_fetch_d = stop_fetch_q || (id_is_hlt && !branch_taken);

    if (branch_taken) begin
      pc_d = branch_target;
    end else if (fetch_en) begin
      pc_d          = PC + 32'd1;
      if_id_d.valid = 1'b1;
      if_id_d.pc    = PC;
      if_id_d.ir    = Mem[PC[AW-1:0]];
    end

    if (if_id_q.valid && !branch_taken) begin
      id_ex_d.valid = 1'b1;
      id_ex_d.cls   = id_cls;
      id_ex_d.op    = id_op;
      id_ex_d.rs    = id_rs;
      id_ex_d.rt    = id_rt;
      id_ex_d.dest  = (id_cls == RR_ALU) ? id_rd : id_rt;
      id_ex_d.we    = (id_cls == RR_ALU) || (id_cls == RM_ALU) || (id_cls == LOAD);
      id_ex_d.a     = id_a;
      id_ex_d.b     = id_b;
      id_ex_d.imm   = id_imm;
      id_ex_d.pc    = if_id_q.pc;
    end

    if (id_ex_q.valid) begin
      ex_mem_d.valid = 1'b1;
      ex_mem_d.cls   = id_ex_q.cls;
      ex_mem_d.dest  = id_ex_q.dest;
      ex_mem_d.we    = id_ex_q.we;
      ex_mem_d.alu   = alu_y;
      ex_mem_d.b     = ex_b;
    end

    if (ex_mem_q.valid) begin
      mem_wb_d.valid  = 1'b1;
      mem_wb_d.cls    = ex_mem_q.cls;
      mem_wb_d.dest   = ex_mem_q.dest;
      mem_wb_d.we     = ex_mem_q.we;
      mem_wb_d.result = (ex_mem_q.cls == LOAD) ? Mem[ex_mem_q.alu[AW-1:0]] : ex_mem_q.alu;
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      stop_fetch_q <= 1'b0;
      if_id_q      <= '0;
      id_ex_q      <= '0;
      ex_mem_q     <= '0;
      mem_wb_q     <= '0;
    end else if (!HALTED) begin
      PC           <= pc_d;
      HALTED       <= mem_wb_q.valid && (mem_wb_q.cls == HALT);
      TAKEN_BRANCH <= branch_taken;
      stop_fetch_q <= stop_fetch_d;
      if_id_q      <= if_id_d;
      id_ex_q      <= id_ex_d;
      ex_mem_q     <= ex_mem_d;
      mem_wb_q     <= mem_wb_d;
    end
  end

  // Architectural arrays have no reset; writes are suppressed while in reset
  // and once halted.
  always_ff @(posedge clk) begin
    if (rst_n && !HALTED) begin
      if (ex_mem_q.valid && ex_mem_q.cls == STORE)
        Mem[ex_mem_q.alu[AW-1:0]] <= ex_mem_q.b;
      if (wb_write)
        Reg[mem_wb_q.dest] <= mem_wb_q.result;
    end
  end

  assign halted = HALTED;

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed testbench for pipe_mips32: preloads programs hierarchically,
// releases reset, polls halted and compares architectural state against
// hand-computed results.
module tb_pipe_mips32;
  import mips32_pkg::*;

  logic clk;
  logic rst_n;
  logic halted;

  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  pipe_mips32 #(.MEM_DEPTH(1024), .XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .halted (halted)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_hlt();
    return {OP_HLT, 26'd0};
  endfunction

  // ---------------- driver tasks ----------------
  // Holds reset and clears memory and registers; program loading follows.
  task automatic enter_reset();
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.Reg[i] = 32'd0;
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    check({tag, "_rst_pc"}, dut.PC, 32'd0);
    check({tag, "_rst_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_rst_taken"}, {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input string tag, input int limit, output int pulses);
    int cycles;
    cycles = 0;
    pulses = 0;
    while (!halted && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (dut.TAKEN_BRANCH) pulses++;
    end
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic load_factorial();
    dut.Mem[0] = enc_i(OP_ADDI, 5'd10, 5'd0, 16'd200);
    dut.Mem[1] = enc_i(OP_ADDI, 5'd2, 5'd0, 16'd1);
    dut.Mem[2] = enc_i(OP_LW, 5'd3, 5'd10, 16'd0);
    dut.Mem[3] = enc_r(OP_OR, 5'd20, 5'd20, 5'd20);
    dut.Mem[4] = enc_r(OP_MUL, 5'd2, 5'd2, 5'd3);
    dut.Mem[5] = enc_i(OP_SUBI, 5'd3, 5'd3, 16'd1);
    dut.Mem[6] = enc_r(OP_OR, 5'd20, 5'd20, 5'd20);
    dut.Mem[7] = enc_i(OP_BNEQZ, 5'd0, 5'd3, 16'hFFFC);
    dut.Mem[8] = enc_i(OP_SW, 5'd2, 5'd10, 16'hFFFE);
    dut.Mem[9] = enc_hlt();
    dut.Mem[200] = 32'd7;
  endtask

  // ---------------- tests ----------------
  initial begin
    int pulses;
    logic [31:0] pc_snap;
    logic [4:0] regs [7];
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;

    // Factorial of 7: six taken branches, result stored at 198.
    enter_reset();
    load_factorial();
    release_reset("fact");
    run_to_halt("fact", 100, pulses);
    check("fact_mem198", dut.Mem[198], 32'd5040);
    check("fact_mem200", dut.Mem[200], 32'd7);
    check("fact_r3", dut.Reg[3], 32'd0);
    check("fact_r2", dut.Reg[2], 32'd5040);
    check("fact_taken_pulses", pulses, 32'd6);
    check("fact_pc", dut.PC, 32'd10);

    // Forwarding chains through EX/MEM and MEM/WB, plus the remaining ALU ops.
    enter_reset();
    dut.Reg[2]  = 32'd2;
    dut.Reg[3]  = 32'd3;
    dut.Reg[12] = 32'hFFFF_FFFF;
    dut.Mem[0] = enc_r(OP_ADD, 5'd1, 5'd2, 5'd3);
    dut.Mem[1] = enc_r(OP_ADD, 5'd4, 5'd1, 5'd1);
    dut.Mem[2] = enc_r(OP_SUB, 5'd7, 5'd4, 5'd1);
    dut.Mem[3] = enc_r(OP_SLT, 5'd8, 5'd7, 5'd4);
    dut.Mem[4] = enc_r(OP_AND, 5'd9, 5'd4, 5'd2);
    dut.Mem[5] = enc_i(OP_SLTI, 5'd11, 5'd12, 16'd0);
    dut.Mem[6] = enc_r(OP_MUL, 5'd13, 5'd12, 5'd3);
    dut.Mem[7] = enc_hlt();
    release_reset("fwd");
    run_to_halt("fwd", 60, pulses);
    regs = '{5'd1, 5'd4, 5'd7, 5'd8, 5'd9, 5'd11, 5'd13};
    exp_q = '{32'd5, 32'd10, 32'd5, 32'd1, 32'd2, 32'd1, 32'hFFFF_FFFD};
    foreach (regs[i]) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check($sformatf("fwd_r%0d", regs[i]), dut.Reg[regs[i]], e);
    end

    // Load-use without interlock: first consumer sees the old value.
    enter_reset();
    dut.Reg[3] = 32'd4;
    dut.Mem[50] = 32'h123;
    dut.Mem[0] = enc_i(OP_LW, 5'd3, 5'd0, 16'd50);
    dut.Mem[1] = enc_r(OP_ADD, 5'd4, 5'd3, 5'd0);
    dut.Mem[2] = enc_r(OP_ADD, 5'd5, 5'd3, 5'd0);
    dut.Mem[3] = enc_hlt();
    release_reset("ldu");
    run_to_halt("ldu", 40, pulses);
    check("ldu_r4_stale", dut.Reg[4], 32'd4);
    check("ldu_r5_fwd", dut.Reg[5], 32'h123);
    check("ldu_r3", dut.Reg[3], 32'h123);

    // Taken BEQZ flushes the two younger instructions.
    enter_reset();
    dut.Reg[5] = 32'h55;
    dut.Mem[300] = 32'hAA;
    dut.Mem[0] = enc_i(OP_BEQZ, 5'd0, 5'd0, 16'd2);
    dut.Mem[1] = enc_i(OP_ADDI, 5'd5, 5'd0, 16'd9);
    dut.Mem[2] = enc_i(OP_SW, 5'd5, 5'd0, 16'd300);
    dut.Mem[3] = enc_hlt();
    release_reset("br");
    run_to_halt("br", 40, pulses);
    check("br_r5", dut.Reg[5], 32'h55);
    check("br_mem300", dut.Mem[300], 32'hAA);
    check("br_taken_pulses", pulses, 32'd1);

    // R0 ignores writes and reads as zero.
    enter_reset();
    dut.Reg[6] = 32'h66;
    dut.Mem[0] = enc_i(OP_ADDI, 5'd0, 5'd0, 16'd7);
    dut.Mem[1] = enc_r(OP_ADD, 5'd6, 5'd0, 5'd0);
    dut.Mem[2] = enc_hlt();
    release_reset("r0");
    run_to_halt("r0", 40, pulses);
    check("r0_r6", dut.Reg[6], 32'd0);
    check("r0_r0", dut.Reg[0], 32'd0);

    // Nothing after HLT executes and the core stays frozen.
    enter_reset();
    dut.Mem[300] = 32'hAA;
    dut.Mem[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 16'h77);
    dut.Mem[1] = enc_hlt();
    dut.Mem[2] = enc_i(OP_SW, 5'd1, 5'd0, 16'd300);
    release_reset("hlt");
    run_to_halt("hlt", 40, pulses);
    check("hlt_r1", dut.Reg[1], 32'h77);
    check("hlt_pc", dut.PC, 32'd2);
    pc_snap = dut.PC;
    repeat (5) @(negedge clk);
    check("hlt_mem300", dut.Mem[300], 32'hAA);
    check("hlt_pc_frozen", dut.PC, pc_snap);
    check("hlt_still_halted", {31'd0, halted}, 32'd1);

    // One-cycle reset in the middle of the factorial loop, then rerun.
    enter_reset();
    load_factorial();
    release_reset("mid");
    repeat (20) @(negedge clk);
    check("mid_not_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_pc", dut.PC, 32'd0);
    check("mid_rst_halted", {31'd0, dut.HALTED}, 32'd0);
    check("mid_rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    rst_n = 1'b1;
    run_to_halt("mid", 100, pulses);
    check("mid_mem198", dut.Mem[198], 32'd5040);
    check("mid_r3", dut.Reg[3], 32'd0);
    check("mid_taken_pulses", pulses, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
